// File: rtl/axil_enc_arbiter_pkg.sv
// axil_enc_arbiter_pkg: shared types and constants for the PmodENC544 AXI4-Lite arbiter.
//   - arb_state_e : transaction FSM states
//   - RespOkay / RespSlverr : AXI response codes
//   - RegOffset0..3 : byte offsets of the PmodENC544 register window
//   - onehot2 : turns a 1-bit requester index into a 2-bit one-hot vector
package axil_enc_arbiter_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StWrReq,
      StWrResp,
      StRdReq,
      StRdData,
      StDone
   } arb_state_e;

   localparam logic [1:0] RespOkay   = 2'b00;
   localparam logic [1:0] RespSlverr = 2'b10;

   localparam logic [3:0] RegOffset0 = 4'h0;
   localparam logic [3:0] RegOffset1 = 4'h4;
   localparam logic [3:0] RegOffset2 = 4'h8;
   localparam logic [3:0] RegOffset3 = 4'hC;

   function automatic logic [1:0] onehot2(input logic idx);
      return idx ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/axil_enc_arbiter_if.sv
// axil_enc_arbiter_if: AXI4-Lite bus between the arbiter (master) and the PmodENC544 window.
//   Parameter ADDR_WIDTH : byte-address width.
//   Channels: AW (awaddr/awprot/awvalid/awready), W (wdata/wstrb/wvalid/wready),
//             B (bresp/bvalid/bready), AR (araddr/arprot/arvalid/arready),
//             R (rdata/rresp/rvalid/rready).
//   Modports: master (arbiter side), slave (register window side).
interface axil_enc_arbiter_if #(
   parameter int unsigned ADDR_WIDTH = 4
) ();

   logic [ADDR_WIDTH-1:0] awaddr;
   logic [2:0]            awprot;
   logic                  awvalid;
   logic                  awready;
   logic [31:0]           wdata;
   logic [3:0]            wstrb;
   logic                  wvalid;
   logic                  wready;
   logic [1:0]            bresp;
   logic                  bvalid;
   logic                  bready;
   logic [ADDR_WIDTH-1:0] araddr;
   logic [2:0]            arprot;
   logic                  arvalid;
   logic                  arready;
   logic [31:0]           rdata;
   logic [1:0]            rresp;
   logic                  rvalid;
   logic                  rready;

   modport master (
      output awaddr, awprot, awvalid, input awready,
      output wdata, wstrb, wvalid, input wready,
      input bresp, bvalid, output bready,
      output araddr, arprot, arvalid, input arready,
      input rdata, rresp, rvalid, output rready
   );

   modport slave (
      input awaddr, awprot, awvalid, output awready,
      input wdata, wstrb, wvalid, output wready,
      output bresp, bvalid, input bready,
      input araddr, arprot, arvalid, output arready,
      output rdata, rresp, rvalid, input rready
   );

endinterface

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-input round-robin grant.
//   clk, rst_n : clock, asynchronous active-low reset
//   req        : request vector
//   update     : pulse when the granted transaction completes
//   upd_grant  : index of the requester that just completed
//   grant      : index to grant now (meaningful only when req != 0)
// On a tie the requester not served last wins; after reset requester 0 wins the first tie.
module rr_arbiter2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic       update,
   input  logic       upd_grant,
   output logic       grant
);

   logic last_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_q <= 1'b1;
      end else if (update) begin
         last_q <= upd_grant;
      end
   end

   always_comb begin
      grant = 1'b0;
      if (req == 2'b11) begin
         grant = ~last_q;
      end else if (req[1]) begin
         grant = 1'b1;
      end
   end

endmodule

// File: rtl/axil_enc_arbiter.sv
// axil_enc_arbiter: shares one AXI4-Lite master port to the PmodENC544 register window
// between two requesters, one transaction outstanding at a time.
//   ACLK, ARESETN : clock, asynchronous active-low reset
//   req_valid/req_we/req_addr/req_wdata : per-requester command, held until req_done
//   req_done      : one-cycle completion pulse to the granted requester
//   rsp_rdata/rsp_resp : read data / AXI response, valid with req_done
//   m_axi         : AXI4-Lite master (axil_enc_arbiter_if.master)
// Optional: define ENC_ARB_TIMEOUT_EN to add a response watchdog of TIMEOUT_CYCLES cycles
// that completes a stuck transaction with SLVERR.
module axil_enc_arbiter
   import axil_enc_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH     = 4,
   parameter int unsigned TIMEOUT_CYCLES = 256
) (
   input  logic                    ACLK,
   input  logic                    ARESETN,
   input  logic [1:0]              req_valid,
   input  logic [1:0]              req_we,
   input  logic [2*ADDR_WIDTH-1:0] req_addr,
   input  logic [63:0]             req_wdata,
   output logic [1:0]              req_done,
   output logic [31:0]             rsp_rdata,
   output logic [1:0]              rsp_resp,
   axil_enc_arbiter_if.master      m_axi
);

   arb_state_e            state_q, state_d;
   logic                  grant_q, grant_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [31:0]           wdata_q, wdata_d;
   logic [31:0]           rdata_q, rdata_d;
   logic [1:0]            resp_q, resp_d;
   logic                  aw_done_q, aw_done_d;
   logic                  w_done_q, w_done_d;
   logic                  arb_grant;
   logic                  aw_hs, w_hs;
   logic                  active;
   logic                  tmo_hit;

   rr_arbiter2 u_rr (
      .clk       (ACLK),
      .rst_n     (ARESETN),
      .req       (req_valid),
      .update    (state_q == StDone),
      .upd_grant (grant_q),
      .grant     (arb_grant)
   );

   assign aw_hs  = m_axi.awvalid && m_axi.awready;
   assign w_hs   = m_axi.wvalid && m_axi.wready;
   assign active = (state_q == StWrReq) || (state_q == StWrResp) ||
                   (state_q == StRdReq) || (state_q == StRdData);

`ifdef ENC_ARB_TIMEOUT_EN
   localparam int unsigned CntW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

   logic [CntW-1:0] tmo_cnt_q;

   // Counts every cycle spent waiting on the slave, across all four bus states.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         tmo_cnt_q <= '0;
      end else if (active) begin
         tmo_cnt_q <= tmo_cnt_q + 1'b1;
      end else begin
         tmo_cnt_q <= '0;
      end
   end

   assign tmo_hit = active && (tmo_cnt_q == CntW'(TIMEOUT_CYCLES - 1));
`else
   logic unused_timeout;

   assign tmo_hit        = 1'b0;
   assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      rdata_d   = rdata_q;
      resp_d    = resp_q;
      aw_done_d = aw_done_q;
      w_done_d  = w_done_q;
      unique case (state_q)
         StIdle: begin
            if (|req_valid) begin
               grant_d   = arb_grant;
               addr_d    = arb_grant ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH]
                                     : req_addr[ADDR_WIDTH-1:0];
               wdata_d   = arb_grant ? req_wdata[63:32] : req_wdata[31:0];
               rdata_d   = '0;
               resp_d    = RespOkay;
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
               state_d   = req_we[arb_grant] ? StWrReq : StRdReq;
            end
         end
         StWrReq: begin
            // AW and W complete independently; leave once both have, in any order.
            if (aw_hs) aw_done_d = 1'b1;
            if (w_hs)  w_done_d  = 1'b1;
            if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
               state_d = StWrResp;
            end
         end
         StWrResp: begin
            if (m_axi.bvalid) begin
               resp_d  = m_axi.bresp;
               state_d = StDone;
            end
         end
         StRdReq: begin
            if (m_axi.arready) state_d = StRdData;
         end
         StRdData: begin
            if (m_axi.rvalid) begin
               rdata_d = m_axi.rdata;
               resp_d  = m_axi.rresp;
               state_d = StDone;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
      // A transaction finishing in the expiry cycle still reports the slave's answer.
      if (tmo_hit && (state_d != StDone)) begin
         state_d = StDone;
         resp_d  = RespSlverr;
         rdata_d = '0;
      end
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         state_q   <= StIdle;
         grant_q   <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         rdata_q   <= '0;
         resp_q    <= RespOkay;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         rdata_q   <= rdata_d;
         resp_q    <= resp_d;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
      end
   end

   // Bus outputs decode registered state only, so no READY reaches a VALID combinationally.
   logic unused_addr_lsb;

   assign unused_addr_lsb = ^addr_q[1:0];

   assign m_axi.awaddr  = {addr_q[ADDR_WIDTH-1:2], 2'b00};
   assign m_axi.awprot  = 3'b000;
   assign m_axi.awvalid = (state_q == StWrReq) && !aw_done_q;
   assign m_axi.wdata   = wdata_q;
   assign m_axi.wstrb   = 4'hF;
   assign m_axi.wvalid  = (state_q == StWrReq) && !w_done_q;
   assign m_axi.bready  = (state_q == StWrResp);
   assign m_axi.araddr  = {addr_q[ADDR_WIDTH-1:2], 2'b00};
   assign m_axi.arprot  = 3'b000;
   assign m_axi.arvalid = (state_q == StRdReq);
   assign m_axi.rready  = (state_q == StRdData);

   assign req_done  = (state_q == StDone) ? onehot2(grant_q) : 2'b00;
   assign rsp_rdata = (state_q == StDone) ? rdata_q : 32'h0;
   assign rsp_resp  = (state_q == StDone) ? resp_q : RespOkay;

endmodule

// File: tb/tb_axil_enc_arbiter.sv
module tb_axil_enc_arbiter;
   import axil_enc_arbiter_pkg::*;

   localparam int unsigned AW = 4;
`ifdef ENC_ARB_TIMEOUT_EN
   localparam int unsigned TMO = 16;
`else
   localparam int unsigned TMO = 256;
`endif

   logic        ACLK = 1'b0;
   logic        ARESETN;
   logic [1:0]  req_valid;
   logic [1:0]  req_we;
   logic [7:0]  req_addr;
   logic [63:0] req_wdata;
   logic [1:0]  req_done;
   logic [31:0] rsp_rdata;
   logic [1:0]  rsp_resp;

   axil_enc_arbiter_if #(.ADDR_WIDTH(AW)) bus ();

   axil_enc_arbiter #(
      .ADDR_WIDTH     (AW),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .ACLK      (ACLK),
      .ARESETN   (ARESETN),
      .req_valid (req_valid),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_done  (req_done),
      .rsp_rdata (rsp_rdata),
      .rsp_resp  (rsp_resp),
      .m_axi     (bus)
   );

   always #5 ACLK = ~ACLK;

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // ---------------- slave model (PmodENC544 register window) ----------------
   int          aw_delay = 0, w_delay = 0, b_delay = 0, ar_delay = 0, r_delay = 0;
   bit          no_b = 0;
   logic [1:0]  wr_resp_cfg = 2'b00, rd_resp_cfg = 2'b00;
   logic [31:0] smem [4];
   int          aw_hs_n = 0, w_hs_n = 0, b_hs_n = 0, ar_hs_n = 0, r_hs_n = 0;
   logic [3:0]  last_awaddr, last_araddr, last_wstrb;
   logic [2:0]  last_awprot, last_arprot;
   logic [31:0] last_wdata;
   bit          overlap_bad = 0;
   int          split_n = 0;
   int          aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
   bit          aw_fire, w_fire, b_fire, ar_fire, r_fire;
   bit          aw_seen, w_seen, b_pend, r_pend;

   always @(negedge ACLK) begin
      if (ARESETN !== 1'b1) begin
         bus.awready = 0; bus.wready = 0; bus.bvalid = 0; bus.arready = 0; bus.rvalid = 0;
         bus.bresp = 0; bus.rresp = 0; bus.rdata = 0;
         aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
         aw_fire = 0; w_fire = 0; b_fire = 0; ar_fire = 0; r_fire = 0;
         aw_seen = 0; w_seen = 0; b_pend = 0; r_pend = 0;
      end else begin
         // retire handshakes that completed on the posedge just passed
         if (aw_fire) begin aw_hs_n++; aw_seen = 1; end
         if (w_fire)  begin w_hs_n++;  w_seen = 1;  end
         if (b_fire)  begin b_hs_n++;  bus.bvalid = 0; end
         if (ar_fire) begin ar_hs_n++; r_pend = 1; r_cnt = 0; end
         if (r_fire)  begin r_hs_n++;  bus.rvalid = 0; end
         if (aw_seen && w_seen) begin
            smem[last_awaddr[3:2]] = last_wdata;
            aw_seen = 0; w_seen = 0; b_pend = 1; b_cnt = 0;
         end
         bus.awready = bus.awvalid && (aw_cnt >= aw_delay);
         if (bus.awvalid && !bus.awready) aw_cnt++;
         bus.wready = bus.wvalid && (w_cnt >= w_delay);
         if (bus.wvalid && !bus.wready) w_cnt++;
         bus.arready = bus.arvalid && (ar_cnt >= ar_delay);
         if (bus.arvalid && !bus.arready) ar_cnt++;
         if (b_pend && !bus.bvalid && !no_b) begin
            if (b_cnt >= b_delay) begin
               bus.bvalid = 1; bus.bresp = wr_resp_cfg; b_pend = 0;
            end else b_cnt++;
         end
         if (r_pend && !bus.rvalid) begin
            if (r_cnt >= r_delay) begin
               bus.rvalid = 1; bus.rresp = rd_resp_cfg; bus.rdata = smem[last_araddr[3:2]];
               r_pend = 0;
            end else r_cnt++;
         end
         aw_fire = bus.awvalid && bus.awready;
         if (aw_fire) begin
            last_awaddr = bus.awaddr; last_awprot = bus.awprot; aw_cnt = 0;
         end
         w_fire = bus.wvalid && bus.wready;
         if (w_fire) begin
            last_wdata = bus.wdata; last_wstrb = bus.wstrb; w_cnt = 0;
         end
         ar_fire = bus.arvalid && bus.arready;
         if (ar_fire) begin
            last_araddr = bus.araddr; last_arprot = bus.arprot; ar_cnt = 0;
         end
         b_fire = bus.bvalid && bus.bready;
         r_fire = bus.rvalid && bus.rready;
         if (bus.bready && (bus.awvalid || bus.wvalid)) overlap_bad = 1;
         if (bus.awvalid != bus.wvalid) split_n++;
      end
   end

   // ---------------- reference model ----------------
   logic [31:0] mmem [4];
   logic        model_last;          // requester served last; 1 after reset favours 0 on ties
   bit          exp_tmo = 0;
   logic        cmd_we    [2];
   logic [3:0]  cmd_addr  [2];
   logic [31:0] cmd_wdata [2];
   int          grant_log [$];
   int          last_lat, last_act;

   function automatic logic model_pick(input logic [1:0] pend);
      if (pend == 2'b11) return ~model_last;
      return pend[1];
   endfunction

   function automatic logic bus_busy();
      return bus.awvalid | bus.wvalid | bus.bready | bus.arvalid | bus.rready;
   endfunction

   task automatic run_batch(input logic [1:0] mask);
      logic [1:0]  pend;
      logic        g;
      logic [31:0] exp_rdata;
      logic [1:0]  exp_resp;
      int          cyc, act;
      pend = mask; cyc = 0; act = 0;
      @(negedge ACLK);
      req_we    = {cmd_we[1], cmd_we[0]};
      req_addr  = {cmd_addr[1], cmd_addr[0]};
      req_wdata = {cmd_wdata[1], cmd_wdata[0]};
      req_valid = mask;
      while (pend != 2'b00 && cyc < 100) begin
         @(negedge ACLK);
         cyc++;
         if (bus_busy()) act++;
         if (req_done != 2'b00) begin
            g = model_pick(pend);
            check("done_onehot", req_done, g ? 2'b10 : 2'b01);
            if (cmd_we[g]) begin
               exp_rdata = 32'h0;
               exp_resp  = wr_resp_cfg;
               mmem[cmd_addr[g][3:2]] = cmd_wdata[g];
            end else begin
               exp_rdata = mmem[cmd_addr[g][3:2]];
               exp_resp  = rd_resp_cfg;
            end
            if (exp_tmo) begin
               exp_rdata = 32'h0;
               exp_resp  = RespSlverr;
            end
            check("rsp_rdata", rsp_rdata, exp_rdata);
            check("rsp_resp", rsp_resp, exp_resp);
            model_last = g;
            pend[g] = 1'b0;
            req_valid[g] = 1'b0;
            grant_log.push_back(int'(g));
         end
      end
      check("batch_complete", pend, 2'b00);
      last_lat = cyc;
      last_act = act;
      @(negedge ACLK);
      check("done_single_pulse", req_done, 2'b00);
   endtask

   // ---------------- directed + random sequence ----------------
   int          aw0, w0, b0, ar0, r0, sp0, nwr, nrd, spurious;
   logic [1:0]  msk;

   initial begin
      for (int i = 0; i < 4; i++) begin smem[i] = 0; mmem[i] = 0; end
      ARESETN = 0; req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0;
      repeat (3) @(negedge ACLK);
      #1;
      check("rst_done", req_done, 2'b00);
      check("rst_rdata", rsp_rdata, 32'h0);
      check("rst_resp", rsp_resp, 2'b00);
      check("rst_valid_ready", {bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready},
            5'b0);
      @(negedge ACLK);
      ARESETN = 1;
      model_last = 1'b1;

      // Two requesters colliding twice: order 0,1,0,1
      grant_log.delete();
      cmd_we[0] = 1; cmd_addr[0] = RegOffset2; cmd_wdata[0] = 32'hA5A5_0001;
      cmd_we[1] = 0; cmd_addr[1] = RegOffset2; cmd_wdata[1] = 32'h0;
      run_batch(2'b11);
      cmd_we[0] = 0; cmd_addr[0] = RegOffset2;
      cmd_we[1] = 1; cmd_addr[1] = RegOffset3; cmd_wdata[1] = 32'h1234_5678;
      run_batch(2'b11);
      check("rr_len", grant_log.size(), 4);
      if (grant_log.size() == 4) begin
         check("rr_g0", grant_log[0], 0);
         check("rr_g1", grant_log[1], 1);
         check("rr_g2", grant_log[2], 0);
         check("rr_g3", grant_log[3], 1);
      end

      // Req0 write 1 to 0x4 then read it back, zero-wait slave
      cmd_we[0] = 1; cmd_addr[0] = RegOffset1; cmd_wdata[0] = 32'h0000_0001;
      run_batch(2'b01);
      check("wr_latency", last_lat, 3);
      check("wr_awaddr", last_awaddr, 4'h4);
      check("wr_wstrb", last_wstrb, 4'hF);
      check("wr_awprot", last_awprot, 3'b000);
      cmd_we[0] = 0;
      run_batch(2'b01);
      check("rd_latency", last_lat, 3);
      check("rd_active_cycles", last_act, 2);

      // WREADY three cycles ahead of AWREADY, then both together
      aw0 = aw_hs_n; w0 = w_hs_n; b0 = b_hs_n; sp0 = split_n;
      aw_delay = 3; w_delay = 0;
      cmd_we[1] = 1; cmd_addr[1] = RegOffset3; cmd_wdata[1] = 32'hCAFE_F00D;
      run_batch(2'b10);
      check("split_cycles", split_n - sp0, 3);
      check("split_active", last_act, 5);
      check("split_aw_once", aw_hs_n - aw0, 1);
      check("split_w_once", w_hs_n - w0, 1);
      check("split_b_once", b_hs_n - b0, 1);
      aw_delay = 0; sp0 = split_n;
      cmd_wdata[1] = 32'hBEEF_0002;
      run_batch(2'b10);
      check("same_cycle_split", split_n - sp0, 0);
      check("same_cycle_active", last_act, 2);
      check("no_bready_overlap", overlap_bad, 1'b0);

      // Unaligned read 0x6 with SLVERR from the slave
      rd_resp_cfg = 2'b10;
      cmd_we[0] = 0; cmd_addr[0] = 4'h6;
      run_batch(2'b01);
      check("rd_araddr_aligned", last_araddr, 4'h4);
      check("rd_arprot", last_arprot, 3'b000);
      rd_resp_cfg = 2'b00;

      // Randomised traffic with random slave stalls and responses
      for (int it = 0; it < 40; it++) begin
         msk = 2'($urandom_range(1, 3));
         nwr = 0; nrd = 0;
         for (int r = 0; r < 2; r++) begin
            cmd_we[r]    = 1'($urandom_range(0, 1));
            cmd_addr[r]  = 4'($urandom_range(0, 15));
            cmd_wdata[r] = $urandom;
            if (msk[r]) begin
               if (cmd_we[r]) nwr++; else nrd++;
            end
         end
         aw_delay = $urandom_range(0, 3); w_delay = $urandom_range(0, 3);
         b_delay  = $urandom_range(0, 3); ar_delay = $urandom_range(0, 3);
         r_delay  = $urandom_range(0, 3);
         wr_resp_cfg = 2'($urandom_range(0, 3));
         rd_resp_cfg = 2'($urandom_range(0, 3));
         aw0 = aw_hs_n; w0 = w_hs_n; b0 = b_hs_n; ar0 = ar_hs_n; r0 = r_hs_n;
         run_batch(msk);
         check("rand_aw_count", aw_hs_n - aw0, nwr);
         check("rand_w_count", w_hs_n - w0, nwr);
         check("rand_b_count", b_hs_n - b0, nwr);
         check("rand_ar_count", ar_hs_n - ar0, nrd);
         check("rand_r_count", r_hs_n - r0, nrd);
      end
      aw_delay = 0; w_delay = 0; b_delay = 0; ar_delay = 0; r_delay = 0;
      wr_resp_cfg = 2'b00; rd_resp_cfg = 2'b00;
      check("rand_no_bready_overlap", overlap_bad, 1'b0);

      // Reset during RD_DATA: abandoned, pointer back to favouring requester 0
      cmd_we[0] = 0; cmd_addr[0] = RegOffset0;
      run_batch(2'b01);
      r_delay = 20;
      cmd_we[1] = 0; cmd_addr[1] = RegOffset2;
      @(negedge ACLK);
      req_we = 2'b00; req_addr = {cmd_addr[1], cmd_addr[0]}; req_valid = 2'b10;
      spurious = 0;
      for (int c = 0; c < 20 && !bus.rready; c++) begin
         @(negedge ACLK);
         if (req_done != 2'b00) spurious++;
      end
      check("reached_rd_data", bus.rready, 1'b1);
      ARESETN = 0;
      #1;
      check("rst_mid_valid_ready",
            {bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready}, 5'b0);
      check("rst_mid_done", req_done, 2'b00);
      req_valid = 2'b00;
      repeat (3) begin
         @(negedge ACLK);
         if (req_done != 2'b00) spurious++;
      end
      check("rst_no_done", spurious, 0);
      ARESETN = 1;
      model_last = 1'b1;
      r_delay = 0;
      grant_log.delete();
      cmd_we[0] = 0; cmd_we[1] = 0;
      run_batch(2'b11);
      check("post_rst_first_grant", grant_log.size() > 0 ? grant_log[0] : -1, 0);

`ifdef ENC_ARB_TIMEOUT_EN
      // Slave never answers the write: watchdog completes it with SLVERR
      no_b = 1;
      exp_tmo = 1;
      cmd_we[0] = 1; cmd_addr[0] = RegOffset3; cmd_wdata[0] = 32'h5555_AAAA;
      run_batch(2'b01);
      check("tmo_active_cycles", last_act, TMO);
      exp_tmo = 0;
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: observed running expected finished");
      $fatal(1, "global timeout");
   end

endmodule
